addr_unshift: RTL and testbench

Iterative inverse-shift engine: takes a word produced by the left/right address shifter plus the bits that shift discarded, and restores the original address one bit position per clock. It sits downstream of the address shift logic in the shifter example set, on the recovery/verification path. It uses a valid/ready handshake on both sides.

---
 rtl/addr_unshift_pkg.sv | 14 +
 rtl/addr_unshift_if.sv | 32 +++
 rtl/addr_unshift_step.sv | 21 ++
 rtl/addr_unshift.sv | 106 ++++++++++
 tb/tb_addr_unshift.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_unshift_pkg.sv
// Shared definitions for the address unshift engine: shift direction codes and FSM states.
// Optional rotate-undo support is selected with UNSHIFT_ROTATE_EN.
package addr_unshift_pkg;

    localparam logic LEFT_SHIFT  = 1'b0;
    localparam logic RIGHT_SHIFT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addr_unshift_if.sv
// Request/response bus of the unshift engine; in_rot exists only with UNSHIFT_ROTATE_EN.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface addr_unshift_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_spill;
    logic             in_dir;
    logic [AMT_W-1:0] in_amt;
`ifdef UNSHIFT_ROTATE_EN
    logic             in_rot;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

`ifdef UNSHIFT_ROTATE_EN
    modport master (output in_valid, in_data, in_spill, in_dir, in_amt, in_rot, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_spill, in_dir, in_amt, in_rot, out_ready,
                    output in_ready, out_valid, out_data);
`else
    modport master (output in_valid, in_data, in_spill, in_dir, in_amt, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_spill, in_dir, in_amt, out_ready,
                    output in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/addr_unshift_step.sv
// One restore step: shifts the word opposite to the original shift and inserts one bit.
module addr_unshift_step
    import addr_unshift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             insert_bit_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        if (dir_i == LEFT_SHIFT) begin
            data_o = {insert_bit_i, data_i[WIDTH-1:1]};
        end else begin
            data_o = {data_i[WIDTH-2:0], insert_bit_i};
        end
    end

endmodule

// File: rtl/addr_unshift.sv
// Iterative inverse shifter: restores one bit position per clock from the shifted word plus spill.
// Define UNSHIFT_ROTATE_EN to add the in_rot rotate-undo mode.
module addr_unshift
    import addr_unshift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    addr_unshift_if.slave io,
    output state_e        state_o
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);

    state_e           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] spill_q;
    logic             dir_q;
`ifdef UNSHIFT_ROTATE_EN
    logic             rot_q;
`endif
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic [AMT_W-1:0] cnt_m1;
    logic [AMT_W-1:0] amt_clamped;
    logic             insert_bit;
    logic [WIDTH-1:0] data_d;

    // Out-of-range amounts saturate instead of wrapping.
    assign amt_clamped = (io.in_amt > AMT_MAX) ? AMT_MAX : io.in_amt;
    assign cnt_m1      = cnt_q - 1'b1;

    always_comb begin
        insert_bit = spill_q[cnt_m1];
`ifdef UNSHIFT_ROTATE_EN
        if (rot_q) begin
            insert_bit = (dir_q == LEFT_SHIFT) ? data_q[0] : data_q[WIDTH-1];
        end
`endif
    end

    addr_unshift_step #(.WIDTH(WIDTH)) u_step (
        .data_i       (data_q),
        .dir_i        (dir_q),
        .insert_bit_i (insert_bit),
        .data_o       (data_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            spill_q     <= '0;
            dir_q       <= LEFT_SHIFT;
`ifdef UNSHIFT_ROTATE_EN
            rot_q       <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        data_q  <= io.in_data;
                        spill_q <= io.in_spill;
                        dir_q   <= io.in_dir;
`ifdef UNSHIFT_ROTATE_EN
                        rot_q   <= io.in_rot;
`endif
                        cnt_q   <= amt_clamped;
                        state_q <= (amt_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_m1;
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; it is presented from the next cycle on.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_q;
                    end else if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_addr_unshift.sv
// Scoreboard bench for addr_unshift: directed cases plus random round trips through a forward-shift model.
// Rotate cases are compiled in when UNSHIFT_ROTATE_EN is defined.
`timescale 1ns/1ps
module tb_addr_unshift;
    import addr_unshift_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    bit     rand_rdy  = 1'b0;
    logic [W-1:0] exp_q[$];

    addr_unshift_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    addr_unshift #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Forward shifter model: produces the shifted word and the spill bits a consumer would see.
    function automatic void fwd(input logic [W-1:0] orig, input logic dir, input int amt,
                                input logic rot, output logic [W-1:0] d, output logic [W-1:0] sp);
        d  = orig;
        sp = $urandom();
        for (int i = 0; i < amt; i++) begin
            if (dir == LEFT_SHIFT) begin
                if (!rot) sp[i] = d[W-1];
                d = rot ? {d[W-2:0], d[W-1]} : (d << 1);
            end else begin
                if (!rot) sp[i] = d[0];
                d = rot ? {d[0], d[W-1:1]} : (d >> 1);
            end
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_out: got out_valid with data %h, required no output", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] sp, input logic dir,
                        input int amt, input logic rot, input logic [W-1:0] exp);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", guard);
        end else begin
            bus.in_data  = d;
            bus.in_spill = sp;
            bus.in_dir   = dir;
            bus.in_amt   = AW'(amt);
`ifdef UNSHIFT_ROTATE_EN
            bus.in_rot   = rot;
`else
            if (rot) $display("note: rotate request sent without rotate support");
`endif
            bus.in_valid = 1'b1;
            exp_q.push_back(exp);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Waits for out_valid after an accept, checking latency and that in_ready stays low meanwhile.
    task automatic expect_latency(input string name, input int lat, input bit pulse);
        int c;
        bit busy_ok;
        c = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && c < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            if (pulse && c == 1) begin
                bus.in_data  = 32'hDEAD_BEEF;
                bus.in_amt   = AW'(0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.in_valid = 1'b0;
        check({name, "_latency"}, W'(c), W'(lat));
        check({name, "_busy"}, W'(busy_ok), W'(1));
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && c < max_cyc) begin
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
        end
        bus.out_ready = 1'b1;
        total_cnt++;
        if (c < max_cyc) pass_cnt++;
        else $display("FAIL drain_timeout: got %0d pending results after %0d cycles, required 0", exp_q.size(), c);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] orig, d, sp;
        logic         dir, rot;
        int           amt;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_spill  = '0;
        bus.in_dir    = 1'b0;
        bus.in_amt    = '0;
`ifdef UNSHIFT_ROTATE_EN
        bus.in_rot    = 1'b0;
`endif
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_state", W'(dbg_state), W'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // left undo, amt 1
        send(32'h68AC_F134, 32'hFFFF_FFFE, LEFT_SHIFT, 1, 1'b0, 32'h3456_789A);
        expect_latency("left1", 2, 1'b0);
        drain(50);

        // right undo, amt 1
        send(32'h6263_3C7F, 32'h0000_0001, RIGHT_SHIFT, 1, 1'b0, 32'hC4C6_78FF);
        expect_latency("right1", 2, 1'b0);
        drain(50);

        // multi-bit with an ignored request during RUN
        send(32'hF56F_F9A0, 32'hA5A5_A5AF, LEFT_SHIFT, 4, 1'b0, 32'hFF56_FF9A);
        expect_latency("multi4", 5, 1'b1);
        drain(50);
        repeat (4) begin @(posedge clk); #1; end

        // amt 0 with backpressure
        bus.out_ready = 1'b0;
        send(32'h3FAA_AAAA, 32'hFFFF_FFFF, LEFT_SHIFT, 0, 1'b0, 32'h3FAA_AAAA);
        expect_latency("amt0", 1, 1'b0);
        repeat (3) begin
            check("bp_valid", W'(bus.out_valid), W'(1));
            check("bp_in_ready", W'(bus.in_ready), W'(0));
            @(posedge clk); #1;
        end
        check("bp_valid_last", W'(bus.out_valid), W'(1));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", W'(bus.in_ready), W'(1));
        check("bp_valid_after", W'(bus.out_valid), W'(0));

        // reset during RUN
        orig = $urandom();
        fwd(orig, LEFT_SHIFT, 20, 1'b0, d, sp);
        send(d, sp, LEFT_SHIFT, 20, 1'b0, orig);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_in_ready", W'(bus.in_ready), W'(1));
        check("midrst_state", W'(dbg_state), W'(IDLE));
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        send(32'h68AC_F134, 32'h0000_0000, LEFT_SHIFT, 1, 1'b0, 32'h3456_789A);
        expect_latency("after_rst", 2, 1'b0);
        drain(50);

`ifdef UNSHIFT_ROTATE_EN
        send(32'h8000_0001, 32'h0000_0000, RIGHT_SHIFT, 1, 1'b1, 32'h0000_0003);
        expect_latency("rot_right", 2, 1'b0);
        drain(50);
        send(32'h8000_0001, 32'h0000_0000, LEFT_SHIFT, 1, 1'b1, 32'hC000_0000);
        expect_latency("rot_left", 2, 1'b0);
        drain(50);
`endif

        // random round trips with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            orig = $urandom();
            dir  = 1'($urandom_range(0, 1));
            amt  = (n < 8) ? n : $urandom_range(0, W - 1);
`ifdef UNSHIFT_ROTATE_EN
            rot  = 1'($urandom_range(0, 1));
`else
            rot  = 1'b0;
`endif
            fwd(orig, dir, amt, rot, d, sp);
            send(d, sp, dir, amt, rot, orig);
        end
        drain(400);
        rand_rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("queue_empty", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
